// File: rtl/axi_byte_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI4-Lite to byte-port bridge:
//   - AXI response codes (OKAY / DECERR)
//   - bridge FSM state encoding
//   - control register bit index of the core run enable
//   - lowest_lane(): index of the lowest set bit of a 4-bit lane mask
// ---------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bit of the control register that drives the core's run enable.
  localparam int unsigned RUN_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BYTE = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_BYTE = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_RESP = 3'd5
  } state_t;

  // Lowest set lane of a mask; returns 0 for an empty mask.
  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lane = 2'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/axi_byte_bridge_byte_lane_seq.sv
// ---------------------------------------------------------------------------
// byte_lane_seq
// Walks the set bits of a 4-bit lane mask in ascending order. The mask is
// loaded once per transaction; every advance retires the current lane.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   load_i    load mask_i as the set of pending lanes (wins over advance_i)
//   mask_i    lanes to visit (write strobes, or 4'hF for reads)
//   advance_i retire the current lane
//   lane_o    current (lowest pending) lane
//   valid_o   at least one lane is pending
//   last_o    the current lane is the only one pending
// ---------------------------------------------------------------------------
module byte_lane_seq
  import axi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] mask_i,
  input  logic       advance_i,
  output logic [1:0] lane_o,
  output logic       valid_o,
  output logic       last_o
);

  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] pending_rest;

  // Clearing the lowest set bit retires the current lane.
  assign pending_rest = pending_q & (pending_q - 4'd1);

  always_comb begin
    pending_d = pending_q;
    if (load_i) begin
      pending_d = mask_i;
    end else if (advance_i) begin
      pending_d = pending_rest;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 4'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign lane_o  = lowest_lane(pending_q);
  assign valid_o = |pending_q;
  assign last_o  = valid_o && (pending_rest == 4'd0);

endmodule

// File: rtl/axi_byte_bridge.sv
// ---------------------------------------------------------------------------
// axi_byte_bridge
// AXI4-Lite slave that serializes each 32-bit beat into byte accesses on the
// core's byte-wide data port, plus a control register holding the core's
// run enable.
// Optional feature macro: AXI_BYTE_BRIDGE_DECERR_EN
//   defined   - addresses >= MEM_BYTES (other than CTRL_ADDR) answer DECERR
//               without touching memory, rdata = 0
//   undefined - such addresses wrap modulo MEM_BYTES and answer OKAY
// Ports:
//   sys_clk, rst_n          clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w*    write address / data channels (accepted together)
//   s_axi_b*                write response channel
//   s_axi_ar* / s_axi_r*    read address / data channels
//   mem_en, mem_we          byte access strobe / write enable to the core
//   mem_addr, mem_din       byte address / write data (hold between accesses)
//   mem_dout                byte read data, valid READ_LATENCY cycles after en
//   running                 core run enable (control register bit RUN_BIT)
// ---------------------------------------------------------------------------
module axi_byte_bridge
  import axi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           BUS_WIDTH    = 64,
  parameter int unsigned           MEM_BYTES    = 4096,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR    = 16'hFFFC,
  parameter int unsigned           READ_LATENCY = 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout,
  output logic                  running
);

  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
  localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

`ifdef AXI_BYTE_BRIDGE_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  state_t state_q;
  state_t state_d;

  logic [31:0]           wdata_q;
  logic [MEM_AW-3:0]     base_q;      // word index inside the memory window
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;
  logic [31:0]           rdata_q;
  logic                  running_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [BUS_WIDTH-1:0]  mem_addr_q;
  logic [7:0]            mem_din_q;

  // Address decode: the two byte-offset bits are ignored.
  logic [ADDR_WIDTH-1:0] aw_aligned;
  logic [ADDR_WIDTH-1:0] ar_aligned;
  logic                  aw_ctrl;
  logic                  ar_ctrl;
  logic                  aw_oor;
  logic                  ar_oor;
  logic                  unused_addr_lsbs;

  assign aw_aligned = {s_axi_awaddr[ADDR_WIDTH-1:2], 2'b00};
  assign ar_aligned = {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
  assign aw_ctrl    = (aw_aligned == CTRL_ADDR);
  assign ar_ctrl    = (ar_aligned == CTRL_ADDR);
  assign aw_oor     = DECERR_EN && !aw_ctrl && ({1'b0, aw_aligned} >= MEM_LIMIT);
  assign ar_oor     = DECERR_EN && !ar_ctrl && ({1'b0, ar_aligned} >= MEM_LIMIT);
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  logic wr_hs;
  logic rd_hs;
  logic wr_skip;   // write needs no byte cycles at all
  logic rd_skip;   // read needs no byte cycles at all

  assign wr_hs   = s_axi_awready;
  assign rd_hs   = s_axi_arready;
  assign wr_skip = aw_ctrl || aw_oor || (s_axi_wstrb == 4'd0);
  assign rd_skip = ar_ctrl || ar_oor;

  // Lane sequencer: write strobes select the lanes, reads visit all four.
  logic [3:0] seq_mask;
  logic       seq_advance;
  logic [1:0] seq_lane;
  logic       seq_valid;
  logic       seq_last;
  logic       wait_done;

  assign wait_done   = (wait_q == WAIT_W'(READ_LATENCY - 1));
  assign seq_mask    = wr_hs ? (wr_skip ? 4'd0 : s_axi_wstrb)
                             : (rd_skip ? 4'd0 : 4'hF);
  assign seq_advance = (state_q == ST_WR_BYTE) ||
                       ((state_q == ST_RD_WAIT) && wait_done);

  byte_lane_seq u_lane_seq (
    .clk_i     (sys_clk),
    .rst_ni    (rst_n),
    .load_i    (wr_hs || rd_hs),
    .mask_i    (seq_mask),
    .advance_i (seq_advance),
    .lane_o    (seq_lane),
    .valid_o   (seq_valid),
    .last_o    (seq_last)
  );

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_hs) begin
          state_d = wr_skip ? ST_WR_RESP : ST_WR_BYTE;
        end else if (rd_hs) begin
          state_d = rd_skip ? ST_RD_RESP : ST_RD_BYTE;
        end
      end
      ST_WR_BYTE: if (seq_last || !seq_valid) state_d = ST_WR_RESP;
      ST_WR_RESP: if (s_axi_bready) state_d = ST_IDLE;
      ST_RD_BYTE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (wait_done) begin
          state_d = (seq_last || !seq_valid) ? ST_RD_RESP : ST_RD_BYTE;
        end
      end
      ST_RD_RESP: if (s_axi_rready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. A complete AW+W pair takes priority over a pending AR.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_axi_awready = s_axi_awvalid && s_axi_wvalid;
        s_axi_wready  = s_axi_awvalid && s_axi_wvalid;
        s_axi_arready = s_axi_arvalid && !(s_axi_awvalid && s_axi_wvalid);
      end
      ST_WR_BYTE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      ST_RD_BYTE: mem_en = 1'b1;
      ST_WR_RESP: s_axi_bvalid = 1'b1;
      ST_RD_RESP: s_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  // Byte port: live values during an access, last values otherwise.
  logic [MEM_AW-1:0] lane_addr;
  logic [7:0]        lane_byte;

  assign lane_addr = {base_q, seq_lane};
  assign lane_byte = wdata_q[{seq_lane, 3'b000} +: 8];
  assign mem_addr  = mem_en ? BUS_WIDTH'(lane_addr) : mem_addr_q;
  assign mem_din   = (mem_en && mem_we) ? lane_byte : mem_din_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q    <= 32'd0;
      base_q     <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= 32'd0;
      running_q  <= 1'b0;
      wait_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'd0;
    end else begin
      if (wr_hs) begin
        wdata_q <= s_axi_wdata;
        base_q  <= aw_aligned[MEM_AW-1:2];
        bresp_q <= aw_oor ? RESP_DECERR : RESP_OKAY;
        if (aw_ctrl && s_axi_wstrb[RUN_BIT / 8]) begin
          running_q <= s_axi_wdata[RUN_BIT];
        end
      end
      if (rd_hs) begin
        base_q  <= ar_aligned[MEM_AW-1:2];
        rresp_q <= ar_oor ? RESP_DECERR : RESP_OKAY;
        rdata_q <= 32'd0;
        if (ar_ctrl) rdata_q[RUN_BIT] <= running_q;
      end
      if (state_q == ST_RD_BYTE) begin
        wait_q <= '0;
      end
      // mem_dout is captured at the end of the last wait cycle of each lane.
      if (state_q == ST_RD_WAIT) begin
        if (wait_done) begin
          rdata_q[{seq_lane, 3'b000} +: 8] <= mem_dout;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
      end
      if (mem_en) mem_addr_q <= mem_addr;
      if (mem_en && mem_we) mem_din_q <= mem_din;
    end
  end

  assign s_axi_bresp = bresp_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rdata = rdata_q;
  assign running     = running_q;

endmodule

// File: tb/tb_axi_byte_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_byte_bridge
// Directed and random AXI4-Lite transactions against axi_byte_bridge with a
// byte-wide core memory attached. Expected values come from a transaction
// level model: a byte array mirror of memory plus the run-enable bit.
// Honours AXI_BYTE_BRIDGE_DECERR_EN for the out-of-range expectations.
// ---------------------------------------------------------------------------
module tb_axi_byte_bridge;

  localparam int MEM_BYTES    = 4096;
  localparam int READ_LATENCY = 1;

`ifdef AXI_BYTE_BRIDGE_DECERR_EN
  localparam bit DECERR_TB = 1'b1;
`else
  localparam bit DECERR_TB = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [15:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        running;

  always #5 sys_clk = ~sys_clk;

  axi_byte_bridge #(
    .ADDR_WIDTH   (16),
    .BUS_WIDTH    (64),
    .MEM_BYTES    (MEM_BYTES),
    .CTRL_ADDR    (16'hFFFC),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .running       (running)
  );

  // ---------------- core memory (one cycle read latency) ----------------
  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 73 + 19) ^ (i >> 4));
  endfunction

  logic [7:0]  core_mem [0:MEM_BYTES-1];
  bit          mem_init_done = 1'b0;
  logic [72:0] mem_log [$];   // {we, addr, din} per observed byte access

  always @(posedge sys_clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MEM_BYTES; i++) core_mem[i] <= init_byte(i);
      mem_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) core_mem[mem_addr[11:0]] <= mem_din;
      else        mem_dout <= core_mem[mem_addr[11:0]];
    end
    if (rst_n && mem_en) mem_log.push_back({mem_we, mem_addr, mem_we ? mem_din : 8'h00});
  end

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic       running_ref;
  bit         ar_with_write;
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdelay,
                           output int lat, output logic [1:0] resp);
    int n;
    mem_log.delete();
    @(negedge sys_clk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    if (ar_with_write) s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      @(negedge sys_clk); #1; n++;
    end
    check("aw_w_ready", {s_axi_awready, s_axi_wready}, 2'b11);
    if (s_axi_arvalid) check("ar_blocked_at_aw", s_axi_arready, 1'b0);
    @(negedge sys_clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    #1;
    lat = 1;
    while (!s_axi_bvalid && lat < 64) begin
      if (s_axi_arvalid) check("ar_blocked", s_axi_arready, 1'b0);
      @(negedge sys_clk); #1; lat++;
    end
    resp = s_axi_bresp;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge sys_clk); #1;
      check("b_stable", {s_axi_bvalid, s_axi_bresp}, {1'b1, resp});
      if (s_axi_arvalid) check("ar_blocked_b", s_axi_arready, 1'b0);
    end
    s_axi_bready = 1'b1;
    @(negedge sys_clk); #1;
    s_axi_bready = 1'b0;
    check("b_done", s_axi_bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int rdelay, output int lat,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    mem_log.delete();
    if (!s_axi_arvalid) begin
      @(negedge sys_clk);
      s_axi_araddr = addr; s_axi_arvalid = 1'b1;
      #1;
    end
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge sys_clk); #1; n++;
    end
    check("ar_ready", s_axi_arready, 1'b1);
    @(negedge sys_clk);
    s_axi_arvalid = 1'b0;
    #1;
    lat = 1;
    while (!s_axi_rvalid && lat < 64) begin
      @(negedge sys_clk); #1; lat++;
    end
    data = s_axi_rdata; resp = s_axi_rresp;
    for (int k = 0; k < rdelay; k++) begin
      @(negedge sys_clk); #1;
      check("r_stable", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, resp, data});
    end
    s_axi_rready = 1'b1;
    @(negedge sys_clk); #1;
    s_axi_rready = 1'b0;
    check("r_done", s_axi_rvalid, 1'b0);
  endtask

  // ---------------- model-checked transactions ----------------
  task automatic do_write_chk(input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int bdelay);
    logic [72:0] exp_log [$];
    int          exp_lat, lat, al, a;
    logic [1:0]  exp_resp, resp;
    al = int'(addr) & 32'hFFFC;
    exp_lat = 1; exp_resp = 2'b00;
    if (al == 32'hFFFC) begin
      if (strb[0]) running_ref = data[0];
    end else if (DECERR_TB && al >= MEM_BYTES) begin
      exp_resp = 2'b11;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) begin
          a = (al + i) % MEM_BYTES;
          ref_mem[a] = data[8*i +: 8];
          exp_log.push_back({1'b1, 64'(a), data[8*i +: 8]});
          exp_lat++;
        end
      end
    end
    axi_write(addr, data, strb, bdelay, lat, resp);
    $display("WR addr=%04h data=%08h strb=%h lat=%0d resp=%0d bytes=%0d running=%0d",
             addr, data, strb, lat, resp, mem_log.size(), running);
    check("b_latency", lat, exp_lat);
    check("bresp", resp, exp_resp);
    check("wr_count", mem_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < mem_log.size(); i++)
      check("wr_byte", mem_log[i], exp_log[i]);
    check("running", running, running_ref);
  endtask

  task automatic do_read_chk(input logic [15:0] addr, input int rdelay);
    logic [72:0] exp_log [$];
    int          exp_lat, lat, al, a;
    logic [1:0]  exp_resp, resp;
    logic [31:0] exp_data, data;
    al = int'(addr) & 32'hFFFC;
    exp_lat = 1; exp_resp = 2'b00; exp_data = 32'd0;
    if (al == 32'hFFFC) begin
      exp_data[0] = running_ref;
    end else if (DECERR_TB && al >= MEM_BYTES) begin
      exp_resp = 2'b11;
    end else begin
      exp_lat = 1 + 4 * (1 + READ_LATENCY);
      for (int i = 0; i < 4; i++) begin
        a = (al + i) % MEM_BYTES;
        exp_data[8*i +: 8] = ref_mem[a];
        exp_log.push_back({1'b0, 64'(a), 8'h00});
      end
    end
    axi_read(addr, rdelay, lat, data, resp);
    $display("RD addr=%04h data=%08h lat=%0d resp=%0d bytes=%0d", addr, data, lat, resp, mem_log.size());
    check("r_latency", lat, exp_lat);
    check("rresp", resp, exp_resp);
    check("rdata", data, exp_data);
    check("rd_count", mem_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < mem_log.size(); i++)
      check("rd_byte", mem_log[i], exp_log[i]);
    check("running_rd", running, running_ref);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] addr;
    int          r;
    checks = 0; failures = 0;
    running_ref = 1'b0; ar_with_write = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("rst_b", {s_axi_bvalid, s_axi_bresp}, 3'b000);
    check("rst_r", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, 35'd0);
    check("rst_mem", {mem_en, mem_we, mem_addr, mem_din}, 74'd0);
    check("rst_running", running, 1'b0);

    // Full write, partial write plus readback
    do_write_chk(16'h0010, 32'hDDCCBBAA, 4'hF, 0);
    do_write_chk(16'h0020, 32'h44332211, 4'b0101, 0);
    do_read_chk(16'h0020, 0);
    do_read_chk(16'h0010, 1);
    do_write_chk(16'h0030, 32'h12345678, 4'h0, 0);

    // Control register
    do_write_chk(16'hFFFC, 32'h1, 4'h1, 0);
    do_read_chk(16'hFFFC, 0);
    do_write_chk(16'hFFFC, 32'h0, 4'hE, 0);  // strobe 0 clear: no change
    do_write_chk(16'hFFFC, 32'h0, 4'hF, 0);
    do_read_chk(16'hFFFF, 0);

    // Simultaneous AW/W and AR, with 5 cycles of B backpressure
    s_axi_araddr = 16'h0010;
    ar_with_write = 1'b1;
    do_write_chk(16'h0014, 32'hCAFEF00D, 4'hF, 5);
    ar_with_write = 1'b0;
    check("ar_after_b", s_axi_arready, 1'b1);
    do_read_chk(16'h0010, 2);

    // Out of range
    do_write_chk(16'h2000, 32'hA5A55A5A, 4'hF, 0);
    do_read_chk(16'h2000, 0);
    do_read_chk(16'h0000, 0);

    // Random traffic
    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      addr = 16'($urandom_range(16'h1000 / 4, 16'hFFF8 / 4) * 4) | 16'($urandom_range(0, 3));
      else if (r == 1) addr = 16'hFFFC | 16'($urandom_range(0, 3));
      else             addr = 16'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 1) == 0)
        do_write_chk(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      else
        do_read_chk(addr, int'($urandom_range(0, 3)));
    end

    // Reset during RD_WAIT aborts the read without a response
    do_write_chk(16'hFFFC, 32'h1, 4'h1, 0);
    @(negedge sys_clk);
    s_axi_araddr = 16'h0040; s_axi_arvalid = 1'b1;
    #1;
    check("mid_ar_ready", s_axi_arready, 1'b1);
    @(negedge sys_clk);
    s_axi_arvalid = 1'b0;
    #1;
    check("mid_rd_byte_en", {mem_en, mem_we}, 2'b10);
    @(negedge sys_clk); #1;
    check("mid_rd_wait_en", mem_en, 1'b0);
    rst_n = 1'b0;
    running_ref = 1'b0;
    #1;
    check("mid_rst_out", {s_axi_rvalid, mem_en, running}, 3'b000);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk); #1;
      check("mid_rst_no_rvalid", s_axi_rvalid, 1'b0);
    end
    do_read_chk(16'h0040, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_byte_bridge.md
Name: axi_byte_bridge

Overview:
- AXI4-Lite slave that feeds the core's byte-wide external data port (axi_data_en/we/addr/din/dout) and drives the core's `running` input.
- Host firmware loads program/data images into core memory and reads results back. Each 32-bit AXI beat is serialized into byte accesses.
- Sits directly upstream of `core`. The top level ties core.axi_data_clk to sys_clk.

Parameters:
- ADDR_WIDTH, 16, AXI address width.
- BUS_WIDTH, 64, width of the core-side byte address.
- MEM_BYTES, 4096, size of the core memory window in bytes; must be a power of 2.
- CTRL_ADDR, 16'hFFFC, word address of the control register.
- READ_LATENCY, 1, cycles from mem_en (we=0) to valid mem_dout; must be ≥1.

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- mem_en  out  1  byte access strobe to core
- mem_we  out  1  byte write enable
- mem_addr  out  BUS_WIDTH  byte address
- mem_din  out  8  byte write data
- mem_dout  in  8  byte read data
- running  out  1  core run enable

Behaviour:
- Clock and reset: one clock, sys_clk. rst_n is asynchronous, active-low.
- Reset: all outputs are 0, running=0 and FSM=IDLE. Reset asserted mid-transaction aborts the transaction immediately; no response is issued.
- FSM states: IDLE, WR_BYTE, WR_RESP, RD_BYTE, RD_WAIT, RD_RESP.
- IDLE, handshake acceptance:
  - awready and wready are asserted together, combinationally, only when awvalid && wvalid. AW and W are always accepted in the same cycle.
  - Otherwise arready = arvalid.
  - A write wins over a read pending in the same cycle.
- Address decode:
  - word = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - mem_addr = zero-extended {word, 2'b00} + i, modulo MEM_BYTES.
- Control register access:
  - An address equal to CTRL_ADDR is the control register; no mem cycles are issued.
  - Write: if wstrb[0], running <= wdata[0].
  - Read: rdata = {31'b0, running}.
- WR_BYTE:
  - One cycle per set strobe bit, ascending i = 0..3. Drives mem_en=1, mem_we=1, mem_din=wdata[8i+7:8i].
  - Cleared strobes are skipped at 0 cycles. wstrb=0 goes straight to WR_RESP.
- WR_RESP: bvalid=1, bresp=OKAY, held until bready. Then IDLE.
- Write latency: full-strobe write gives bvalid 5 cycles after the AW/W handshake.
- RD_BYTE / RD_WAIT:
  - For i = 0..3: pulse mem_en=1, we=0 for one cycle, wait READ_LATENCY cycles, capture mem_dout into rdata[8i+7:8i].
- RD_RESP: rvalid=1, rresp=OKAY, rdata held stable until rready. Then IDLE.
- Read latency: with READ_LATENCY=1, rvalid rises 4·(1+1)+1 = 9 cycles after the AR handshake.
- Outside RD_BYTE/WR_BYTE: mem_en=0 and mem_we=0. mem_addr and mem_din hold their last value.
- Back-to-back transactions: a new transaction is accepted no earlier than the cycle after the B/R handshake.
- running: changes only via control-register writes and is never cleared by a transaction.

Optional Feature:
- Macro: AXI_BYTE_BRIDGE_DECERR_EN.
- Defined: any address ≥ MEM_BYTES that is not CTRL_ADDR issues no mem cycles and responds bresp/rresp=2'b11 (DECERR), with rdata=0. Latency is the same as for wstrb=0, i.e. the response the cycle after acceptance.
- Undefined: the address is truncated modulo MEM_BYTES and accessed normally, with OKAY.

Decomposition:
- Shared package axi_pkg holds:
  - response codes RESP_OKAY=2'b00 and RESP_DECERR=2'b11;
  - FSM state encodings;
  - the control-register bit index RUN_BIT=0.
- One sub-module, byte_lane_seq: a strobe-driven lane counter that yields the next set lane and a done flag. It is used for both write skipping (strobe mask) and reads (mask 4'hF).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → all outputs 0, running=0. Assert rst_n during RD_WAIT → rvalid stays 0 and FSM returns to IDLE.
- Full write: addr=0x0010, wdata=0xDDCCBBAA, wstrb=4'hF → 4 consecutive mem writes at 0x10..0x13 with din AA, BB, CC, DD; bvalid=1 with OKAY on the 5th cycle.
- Partial write and readback: write wstrb=4'b0101 at 0x0020 → writes only to 0x20 and 0x22. Then read 0x0020 against a memory model with READ_LATENCY=1 → 4 reads, rdata correct, rvalid at cycle 9.
- Control register: write 0x1 to 0xFFFC → running=1 with no mem_en pulses; read 0xFFFC → rdata=0x00000001; write 0x0 → running=0.
- Simultaneous and backpressure: AW/W and AR valid in the same cycle → write served first and AR accepted only after the B handshake. With bready=0 for 5 cycles, bvalid and bresp stay stable.
- Out of range (addr 0x2000, MEM_BYTES=4096):
  - with AXI_BYTE_BRIDGE_DECERR_EN → DECERR and no mem_en;
  - without it → access at 0x000 with OKAY.
